// File: rtl/bcd_time_loader.sv
// Loads a 24-hour HH:MM time from four serially offered BCD digits,
// rejecting out-of-range digits and converting the accepted entry to binary.
module bcd_time_loader (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] dig_in,
  input  logic       dig_valid,
  output logic       dig_ready,
  input  logic       cancel,
  output logic [4:0] ora_out,
  output logic [5:0] minut_out,
  output logic       load_valid,
  output logic       err,
  output logic [1:0] pos
);

  typedef enum logic [2:0] {
    S_H_T  = 3'd0,
    S_H_U  = 3'd1,
    S_M_T  = 3'd2,
    S_M_U  = 3'd3,
    S_CONV = 3'd4
  } state_t;

  state_t     state_reg, state_next;
  logic [1:0] h_t_reg;
  logic [3:0] h_u_reg;
  logic [2:0] m_t_reg;
  logic [3:0] m_u_reg;
  logic [4:0] ora_reg;
  logic [5:0] minut_reg;
  logic       err_reg, load_valid_reg;

  logic       accept;
  logic       digit_ok;
  logic [4:0] ora_next;
  logic [5:0] minut_next;

  // Cancel wins over a simultaneous digit, so the digit is never even checked.
  assign accept = dig_valid && dig_ready && !cancel;

  // Stored tens digits are already range-limited, so narrow registers suffice.
  assign ora_next   = ({3'b000, h_t_reg} * 5'd10) + {1'b0, h_u_reg};
  assign minut_next = ({3'b000, m_t_reg} * 6'd10) + {2'b00, m_u_reg};

  always_comb begin
    digit_ok = 1'b0;
    case (state_reg)
      S_H_T:   digit_ok = (dig_in <= 4'd2);
      S_H_U:   digit_ok = (dig_in <= 4'd9) && !((h_t_reg == 2'd2) && (dig_in > 4'd3));
      S_M_T:   digit_ok = (dig_in <= 4'd5);
      S_M_U:   digit_ok = (dig_in <= 4'd9);
      default: digit_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= S_H_T;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (cancel) begin
      state_next = S_H_T;
    end else begin
      case (state_reg)
        S_H_T:   if (accept) state_next = digit_ok ? S_H_U  : S_H_T;
        S_H_U:   if (accept) state_next = digit_ok ? S_M_T  : S_H_T;
        S_M_T:   if (accept) state_next = digit_ok ? S_M_U  : S_H_T;
        S_M_U:   if (accept) state_next = digit_ok ? S_CONV : S_H_T;
        default: state_next = S_H_T;
      endcase
    end
  end

  always_comb begin
    dig_ready = (state_reg != S_CONV);
    case (state_reg)
      S_H_U:   pos = 2'd1;
      S_M_T:   pos = 2'd2;
      S_M_U:   pos = 2'd3;
      default: pos = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_t_reg        <= '0;
      h_u_reg        <= '0;
      m_t_reg        <= '0;
      m_u_reg        <= '0;
      ora_reg        <= '0;
      minut_reg      <= '0;
      err_reg        <= 1'b0;
      load_valid_reg <= 1'b0;
    end else begin
      err_reg        <= accept && !digit_ok;
      load_valid_reg <= (state_reg == S_CONV) && !cancel;
      if (cancel || (accept && !digit_ok)) begin
        h_t_reg <= '0;
        h_u_reg <= '0;
        m_t_reg <= '0;
        m_u_reg <= '0;
      end else if (accept) begin
        case (state_reg)
          S_H_T:   h_t_reg <= dig_in[1:0];
          S_H_U:   h_u_reg <= dig_in;
          S_M_T:   m_t_reg <= dig_in[2:0];
          S_M_U:   m_u_reg <= dig_in;
          default: ;
        endcase
      end
      if ((state_reg == S_CONV) && !cancel) begin
        ora_reg   <= ora_next;
        minut_reg <= minut_next;
      end
    end
  end

  assign ora_out    = ora_reg;
  assign minut_out  = minut_reg;
  assign err        = err_reg;
  assign load_valid = load_valid_reg;

endmodule

// File: tb/tb_bcd_time_loader.sv
// Scoreboard bench for bcd_time_loader: stimulus pushes expected load/err
// events, a negedge monitor pops and compares them as the DUT raises them.
module tb_bcd_time_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] dig_in = 4'd0;
  logic       dig_valid = 1'b0;
  logic       dig_ready;
  logic       cancel = 1'b0;
  logic [4:0] ora_out;
  logic [5:0] minut_out;
  logic       load_valid;
  logic       err;
  logic [1:0] pos;

  bcd_time_loader dut (
    .clk(clk), .reset(reset), .dig_in(dig_in), .dig_valid(dig_valid),
    .dig_ready(dig_ready), .cancel(cancel), .ora_out(ora_out),
    .minut_out(minut_out), .load_valid(load_valid), .err(err), .pos(pos)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_load;
    int ora;
    int minut;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   ora_m = 0;
  int   min_m = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  // Monitor: every load_valid/err pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (load_valid && err) check("err_and_load_together", 1, 0);
    if (load_valid || err) begin
      if (sb.size() == 0) begin
        check("unexpected_event_load_valid", int'(load_valid), 0);
        check("unexpected_event_err", int'(err), 0);
      end else begin
        mon_e = sb.pop_front();
        check("event_kind_is_load", int'(load_valid), int'(mon_e.is_load));
        check("event_cycle", cyc, mon_e.cyc);
        check("event_ora_out", int'(ora_out), mon_e.ora);
        check("event_minut_out", int'(minut_out), mon_e.minut);
        $display("event %s ora=%0d minut=%0d cycle=%0d", load_valid ? "load" : "err",
                 ora_out, minut_out, cyc);
      end
    end
  end

  task automatic send(input logic [3:0] d, output int k);
    int n;
    n = 0;
    @(negedge clk);
    while (!dig_ready && n < 4) begin
      @(negedge clk);
      n++;
    end
    if (!dig_ready) check("dig_ready_timeout", 0, 1);
    dig_in = d;
    dig_valid = 1'b1;
    @(posedge clk);
    #1;
    dig_valid = 1'b0;
    k = cyc;
  endtask

  task automatic load4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic [3:0] d, input int eh, input int em);
    int k;
    send(a, k);
    send(b, k);
    send(c, k);
    send(d, k);
    sb.push_back('{1'b1, eh, em, k + 1});
    ora_m = eh;
    min_m = em;
    $display("entry %0d%0d:%0d%0d expect %0d:%0d", a, b, c, d, eh, em);
    @(negedge clk);
    check("dig_ready_low_in_conv", int'(dig_ready), 0);
    @(negedge clk);
    check("dig_ready_high_after_conv", int'(dig_ready), 1);
  endtask

  task automatic rej(input logic [3:0] d);
    int k;
    send(d, k);
    sb.push_back('{1'b0, ora_m, min_m, k});
    $display("reject digit %0d", d);
    check("pos_after_reject", int'(pos), 0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_ora_out"}, int'(ora_out), 0);
    check({tag, "_minut_out"}, int'(minut_out), 0);
    check({tag, "_pos"}, int'(pos), 0);
    check({tag, "_dig_ready"}, int'(dig_ready), 1);
    check({tag, "_load_valid"}, int'(load_valid), 0);
    check({tag, "_err"}, int'(err), 0);
  endtask

  initial begin
    int k;
    @(negedge clk);
    check_cleared("reset");
    @(negedge clk);
    reset = 1'b0;

    load4(4'd1, 4'd7, 4'd4, 4'd5, 17, 45);
    load4(4'd2, 4'd3, 4'd5, 4'd9, 23, 59);
    load4(4'd0, 4'd0, 4'd0, 4'd0, 0, 0);
    load4(4'd1, 4'd1, 4'd1, 4'd1, 11, 11);

    send(4'd2, k);
    rej(4'd4);
    send(4'd0, k);
    send(4'd9, k);
    rej(4'd6);
    rej(4'hA);

    // Cancel together with a digit: digit ignored, no err.
    send(4'd1, k);
    send(4'd2, k);
    @(negedge clk);
    cancel = 1'b1;
    dig_valid = 1'b1;
    dig_in = 4'd3;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    dig_valid = 1'b0;
    $display("cancel with digit 3");
    check("pos_after_cancel", int'(pos), 0);
    load4(4'd0, 4'd8, 4'd3, 4'd0, 8, 30);

    // Cancel while in CONV aborts the load.
    send(4'd1, k);
    send(4'd2, k);
    send(4'd3, k);
    send(4'd4, k);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    $display("cancel in conv");
    check("cancel_conv_ora_kept", int'(ora_out), 8);
    check("cancel_conv_minut_kept", int'(minut_out), 30);
    check("cancel_conv_pos", int'(pos), 0);

    // Reset after three digits.
    send(4'd1, k);
    send(4'd2, k);
    send(4'd3, k);
    reset = 1'b1;
    @(negedge clk);
    $display("reset mid-entry");
    check_cleared("reset_mid");
    reset = 1'b0;
    ora_m = 0;
    min_m = 0;
    load4(4'd2, 4'd1, 4'd3, 4'd7, 21, 37);

    // Reset during CONV.
    send(4'd1, k);
    send(4'd9, k);
    send(4'd5, k);
    send(4'd8, k);
    reset = 1'b1;
    @(negedge clk);
    $display("reset in conv");
    check_cleared("reset_conv");
    reset = 1'b0;
    ora_m = 0;
    min_m = 0;
    load4(4'd1, 4'd2, 4'd0, 4'd0, 12, 0);

    // Idle cycles mid-entry hold state.
    send(4'd1, k);
    send(4'd5, k);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("pos_hold_idle", int'(pos), 2);
    end
    $display("idle 5 cycles at pos 2");
    send(4'd4, k);
    send(4'd2, k);
    sb.push_back('{1'b1, 15, 42, k + 1});
    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bcd_time_loader.md
BCD_TIME_LOADER -- requirements
Module: bcd_time_loader

Parameters
REQ-001 SHALL have no parameters; hour limit 23 and minute limit 59 are fixed.

Interface
REQ-002 SHALL have: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have: dig_in  input  4  BCD digit being offered.
REQ-005 SHALL have: dig_valid  input  1  dig_in is valid this cycle.
REQ-006 SHALL have: dig_ready  output  1  block accepts a digit this cycle.
REQ-007 SHALL have: cancel  input  1  abort the current entry.
REQ-008 SHALL have: ora_out  output  5  loaded hour, binary, 0..23.
REQ-009 SHALL have: minut_out  output  6  loaded minute, binary, 0..59.
REQ-010 SHALL have: load_valid  output  1  one-cycle pulse when ora_out/minut_out update.
REQ-011 SHALL have: err  output  1  one-cycle pulse when an entered digit is rejected.
REQ-012 SHALL have: pos  output  2  count of digits accepted in the current entry, 0..3.

Function
REQ-013 SHALL accept a digit only on a clk edge where dig_valid=1 and dig_ready=1.
REQ-014 SHALL take digits in this order: hour tens (H_T), hour units (H_U), minute tens (M_T), minute units (M_U).
REQ-015 SHALL use states H_T, H_U, M_T, M_U and CONV, with pos = 0, 1, 2, 3 in H_T..M_U and pos = 0 in CONV.
REQ-016 SHALL accept a digit under these rules: H_T ≤ 2; H_U ≤ 9, and ≤ 3 when the stored H_T = 2; M_T ≤ 5; M_U ≤ 9. Values 4'hA..4'hF are always rejected.
REQ-017 SHALL handle a rejected digit by pulsing err on the next cycle, discarding all partial digits and returning to H_T; ora_out and minut_out are unchanged.
REQ-018 SHALL move H_T→H_U→M_T→M_U→CONV on each accepted valid digit, and hold state when no digit is accepted.
REQ-019 SHALL drive dig_ready = 1 in H_T..M_U and 0 in CONV, which lasts exactly one cycle.
REQ-020 SHALL register, on the edge that leaves CONV, ora_out = H_T*10 + H_U and minut_out = M_T*10 + M_U. Arithmetic is unsigned and zero-extended to the output width; no intermediate value exceeds 7 bits.
REQ-021 SHALL assert load_valid for exactly the one cycle after the edge leaving CONV, then return to H_T. Latency is 2 edges from acceptance of the M_U digit to load_valid high.
REQ-022 SHALL hold ora_out and minut_out stable between loads.
REQ-023 SHALL, when cancel=1 at an edge, return to H_T, clear partial digits and pos, with no err and no load_valid.
REQ-024 SHALL give cancel priority over a simultaneous digit; the digit is not accepted and its validity is not checked.
REQ-025 SHALL, when cancel=1 in CONV, abort the load: no output update and no load_valid.
REQ-026 SHALL never assert err and load_valid in the same cycle.
REQ-027 SHALL register err and load_valid; both SHALL be 0 in every cycle not specified above.

Reset
REQ-028 SHALL, while reset=1, force and hold: state H_T, partial digits 0, ora_out=0, minut_out=0, load_valid=0, err=0, pos=0, dig_ready=1.
REQ-029 SHALL, when reset is asserted mid-entry or in CONV, discard the entry without any load_valid or err pulse.
REQ-030 SHALL resume operation on the first clk edge after reset deasserts.

Verification
REQ-031 SHALL cover: digits 1,7,4,5 back-to-back → load_valid 2 edges after the 5 is accepted; ora_out=17, minut_out=45; dig_ready low exactly 1 cycle.
REQ-032 SHALL cover: digits 2,3,5,9 → ora_out=23, minut_out=59; then 0,0,0,0 → ora_out=0, minut_out=0.
REQ-033 SHALL cover: digits 2,4 → err pulse after the 4, pos=0, outputs unchanged; and 0,9,6 → err at the 6; and a first digit of 4'hA → err.
REQ-034 SHALL cover: after 1,2 accepted, cancel=1 together with dig_valid=1 and dig_in=3 → pos=0, no err, no load_valid; a following 0,8,3,0 → ora_out=8, minut_out=30.
REQ-035 SHALL cover: reset pulsed after 3 digits accepted, and separately during CONV → all outputs 0, no load_valid; a following 1,2,0,0 → ora_out=12, minut_out=0.
REQ-036 SHALL cover: dig_valid held low for 5 cycles mid-entry → state and pos hold; entry completes correctly afterwards.
